// File: rtl/put_param_pkg.sv
// ---------------------------------------------------------------------------
// put_param_pkg
// Shared constants and types for the InexRecur parameter write path
// (put_param) and its buffer (param_fifo). The fetch side uses the same
// widths and state-word layout.
//   PARAM_W      width of each of i, z, k, l
//   POS_W        width of the execution position
//   INEXRECUR_W  packed parameter word {i, z, k, l}
//   STATE_W      state word {valid, position, index}
// ---------------------------------------------------------------------------
package put_param_pkg;

  localparam int PARAM_W         = 8;
  localparam int POS_W           = 4;
  localparam int INEXRECUR_W     = 32;
  localparam int STATE_W         = 17;

  // State-word layout: valid bit 16, position [15:12], entry index [11:0].
  localparam int STATE_VALID_BIT = 16;
  localparam int STATE_POS_LSB   = 12;
  localparam int STATE_IDX_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } put_state_t;

  // One buffered result; the field order fixes the 37-bit FIFO word layout.
  typedef struct packed {
    logic               last;
    logic [POS_W-1:0]   position;
    logic [PARAM_W-1:0] i;
    logic [PARAM_W-1:0] z;
    logic [PARAM_W-1:0] k;
    logic [PARAM_W-1:0] l;
  } param_entry_t;

  localparam int ENTRY_W = $bits(param_entry_t);

  // Builds the occupancy/position record written alongside each parameter word.
  function automatic logic [STATE_W-1:0] pack_state(
    input logic [POS_W-1:0]       position,
    input logic [STATE_IDX_W-1:0] idx
  );
    logic [STATE_W-1:0] word;
    word                                = '0;
    word[STATE_VALID_BIT]               = 1'b1;
    word[STATE_POS_LSB +: POS_W]        = position;
    word[0 +: STATE_IDX_W]              = idx;
    return word;
  endfunction

endpackage

// File: rtl/param_fifo.sv
// ---------------------------------------------------------------------------
// param_fifo
// Synchronous FIFO buffering compute-stage results ahead of the register
// file writes. Supports simultaneous push and pop, including push while full
// when the same cycle pops.
//   clk, rst_n  clock and synchronous active-low reset
//   clr         synchronous flush (drops all contents)
//   push, wdata write side
//   pop, rdata  read side; rdata shows the head entry while not empty
//   full, empty occupancy flags derived from the registered count
// ---------------------------------------------------------------------------
module param_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 37
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; count/pointers gate every read, so
  // stale words are never observed and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/put_param.sv
// ---------------------------------------------------------------------------
// put_param
// Write side of the InexRecur parameter path. Accepts (i, z, k, l, position)
// results over valid/ready, buffers them, and drains one per cycle into
// regfile_InexRecur and regfile_state at sequential addresses, then pulses
// write_finish once the batch (terminated by last_in) is fully written.
//   clk, rst_n                      clock, synchronous active-low reset
//   en_put_param                    high starts/keeps a round; low aborts
//   in_valid/in_ready               input handshake
//   i_in, z_in, k_in, l_in          parameters
//   position_in, last_in            execution position, end-of-batch marker
//   waddr/wdata/we_reg_InexRecur    packed parameter write port
//   waddr/wdata/we_reg_state        state record write port (same addr/we)
//   entry_count                     entries written this round
//   overflow                        sticky: an entry was dropped, regfile full
//   write_finish                    one-cycle batch completion pulse
// ---------------------------------------------------------------------------
module put_param
  import put_param_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_put_param,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PARAM_W-1:0]     i_in,
  input  logic [PARAM_W-1:0]     z_in,
  input  logic [PARAM_W-1:0]     k_in,
  input  logic [PARAM_W-1:0]     l_in,
  input  logic [POS_W-1:0]       position_in,
  input  logic                   last_in,
  output logic [ADDR_W-1:0]      waddr_reg_InexRecur,
  output logic [INEXRECUR_W-1:0] wdata_reg_InexRecur,
  output logic                   we_reg_InexRecur,
  output logic [ADDR_W-1:0]      waddr_reg_state,
  output logic [STATE_W-1:0]     wdata_reg_state,
  output logic                   we_reg_state,
  output logic [ADDR_W:0]        entry_count,
  output logic                   overflow,
  output logic                   write_finish
);

  put_state_t   state;
  param_entry_t in_entry;
  param_entry_t head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_clr;
  logic         active;
  logic         accept;
  logic         pop_fire;
  logic         rf_full;
  logic         last_popped;
  logic [ADDR_W-1:0] wptr;

  assign in_entry = {last_in, position_in, i_in, z_in, k_in, l_in};

  assign active   = (state == ST_RUN) || (state == ST_FLUSH);
  // Drain stops on the very edge that sees the abort, so no write follows it.
  assign pop_fire = active && en_put_param && !fifo_empty;
  assign in_ready = (state == ST_RUN) && (!fifo_full || pop_fire);
  assign accept   = in_valid && in_ready;
  assign fifo_clr = active && !en_put_param;

  // entry_count saturates at 2^ADDR_W, so its MSB alone flags a full regfile.
  assign rf_full  = entry_count[ADDR_W];

  // Both register files share one address and enable.
  assign waddr_reg_state = waddr_reg_InexRecur;
  assign we_reg_state    = we_reg_InexRecur;

  param_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fifo_clr),
    .push  (accept),
    .wdata (in_entry),
    .pop   (pop_fire),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      wptr                <= '0;
      entry_count         <= '0;
      overflow            <= 1'b0;
      last_popped         <= 1'b0;
      we_reg_InexRecur    <= 1'b0;
      waddr_reg_InexRecur <= '0;
      wdata_reg_InexRecur <= '0;
      wdata_reg_state     <= '0;
      write_finish        <= 1'b0;
    end else begin
      // Enables and the finish strobe are single-cycle unless re-asserted.
      we_reg_InexRecur <= 1'b0;
      write_finish     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (en_put_param) begin
            wptr        <= '0;
            entry_count <= '0;
            overflow    <= 1'b0;
            last_popped <= 1'b0;
            state       <= ST_RUN;
          end
        end

        ST_RUN, ST_FLUSH: begin
          if (!en_put_param) begin
            state <= ST_IDLE;
          end else begin
            if (state == ST_RUN && accept && last_in) state <= ST_FLUSH;

            // Wait for the final registered write to retire before finishing.
            if (state == ST_FLUSH && fifo_empty && !we_reg_InexRecur && last_popped) begin
              state        <= ST_DONE;
              write_finish <= 1'b1;
            end

            if (pop_fire) begin
              if (head.last) last_popped <= 1'b1;
              if (rf_full) begin
                overflow <= 1'b1;
              end else begin
                we_reg_InexRecur    <= 1'b1;
                waddr_reg_InexRecur <= wptr;
                wdata_reg_InexRecur <= {head.i, head.z, head.k, head.l};
                wdata_reg_state     <= pack_state(head.position, STATE_IDX_W'(wptr));
                wptr                <= wptr + ADDR_W'(1);
                entry_count         <= entry_count + (ADDR_W+1)'(1);
              end
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_put_param.sv
// ---------------------------------------------------------------------------
// tb_put_param
// Self-checking bench for put_param. Two instances share all inputs: dut_a
// (ADDR_W=8) for normal operation and dut_b (ADDR_W=2) whose 4-entry regfile
// exercises the overflow path. Writes are collected on the falling edge and
// compared with expectations computed from the entry list of each round.
// ---------------------------------------------------------------------------
module tb_put_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en_put_param, in_valid, last_in;
  logic [7:0] i_in, z_in, k_in, l_in;
  logic [3:0] position_in;

  logic        in_ready_a, we_ir_a, we_st_a, overflow_a, write_finish_a;
  logic [7:0]  waddr_ir_a, waddr_st_a;
  logic [31:0] wdata_ir_a;
  logic [16:0] wdata_st_a;
  logic [8:0]  entry_count_a;

  logic        in_ready_b, we_ir_b, we_st_b, overflow_b, write_finish_b;
  logic [1:0]  waddr_ir_b, waddr_st_b;
  logic [31:0] wdata_ir_b;
  logic [16:0] wdata_st_b;
  logic [2:0]  entry_count_b;

  put_param #(.ADDR_W(8), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_put_param(en_put_param),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .i_in(i_in), .z_in(z_in), .k_in(k_in), .l_in(l_in),
    .position_in(position_in), .last_in(last_in),
    .waddr_reg_InexRecur(waddr_ir_a), .wdata_reg_InexRecur(wdata_ir_a),
    .we_reg_InexRecur(we_ir_a), .waddr_reg_state(waddr_st_a),
    .wdata_reg_state(wdata_st_a), .we_reg_state(we_st_a),
    .entry_count(entry_count_a), .overflow(overflow_a),
    .write_finish(write_finish_a)
  );

  put_param #(.ADDR_W(2), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_put_param(en_put_param),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .i_in(i_in), .z_in(z_in), .k_in(k_in), .l_in(l_in),
    .position_in(position_in), .last_in(last_in),
    .waddr_reg_InexRecur(waddr_ir_b), .wdata_reg_InexRecur(wdata_ir_b),
    .we_reg_InexRecur(we_ir_b), .waddr_reg_state(waddr_st_b),
    .wdata_reg_state(wdata_st_b), .we_reg_state(we_st_b),
    .entry_count(entry_count_b), .overflow(overflow_b),
    .write_finish(write_finish_b)
  );

  typedef struct packed {
    logic [7:0] i, z, k, l;
    logic [3:0] p;
  } ent_t;

  typedef struct packed {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] d_ir;
    logic [16:0] d_st;
  } wr_t;

  typedef struct {
    ent_t        e;
    logic [31:0] exp_ir;
    logic [16:0] exp_st;
  } vec_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  fin_a = 0, fin_b = 0;
  int  mirror_bad = 0;
  wr_t got_a[$];
  wr_t got_b[$];

  always @(posedge clk) cyc++;

  // Falling-edge monitor: capture every write and finish pulse.
  always @(negedge clk) begin
    if (we_ir_a === 1'b1) got_a.push_back('{cyc: cyc, addr: waddr_ir_a, d_ir: wdata_ir_a, d_st: wdata_st_a});
    if (we_ir_b === 1'b1) got_b.push_back('{cyc: cyc, addr: {6'b0, waddr_ir_b}, d_ir: wdata_ir_b, d_st: wdata_st_b});
    if (write_finish_a === 1'b1) fin_a++;
    if (write_finish_b === 1'b1) fin_b++;
    if (we_ir_a !== we_st_a || waddr_ir_a !== waddr_st_a ||
        we_ir_b !== we_st_b || waddr_ir_b !== waddr_st_b) mirror_bad++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{in_ready_a, we_ir_a, we_st_a, waddr_ir_a, waddr_st_a, wdata_ir_a, wdata_st_a,
             entry_count_a, overflow_a, write_finish_a,
             in_ready_b, we_ir_b, we_st_b, waddr_ir_b, waddr_st_b, wdata_ir_b, wdata_st_b,
             entry_count_b, overflow_b, write_finish_b};
  endfunction

  // Expected state word from the field layout: valid, position, index.
  function automatic logic [16:0] exp_state(input logic [3:0] p, input int idx);
    return 17'h10000 | (17'(p) << 12) | 17'(idx);
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.i = 8'($urandom); e.z = 8'($urandom); e.k = 8'($urandom); e.l = 8'($urandom);
    e.p = 4'($urandom);
    return e;
  endfunction

  function automatic void clear_mon();
    got_a.delete(); got_b.delete();
    fin_a = 0; fin_b = 0;
  endfunction

  // Offer one entry; ok=1 once an edge takes it. waits = edges spent.
  task automatic push(input ent_t e, input logic last, output bit ok, output int waits);
    i_in = e.i; z_in = e.z; k_in = e.k; l_in = e.l; position_in = e.p;
    last_in = last; in_valid = 1'b1;
    ok = 1'b0; waits = 0;
    while (!ok && waits < 20) begin
      ok = in_ready_a;
      tick();
      waits++;
    end
    in_valid = 1'b0; last_in = 1'b0;
  endtask

  // One complete round of n entries, checked against the per-round model.
  task automatic run_round(input int n, input bit gaps);
    ent_t ents[$];
    bit   ok, done;
    int   waits, stalls, cap_b, exp_b;
    clear_mon();
    stalls = 0;
    en_put_param = 1'b1;
    tick();
    for (int k = 0; k < n; k++) begin
      ent_t e;
      e = rand_ent();
      ents.push_back(e);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      push(e, (k == n - 1), ok, waits);
      check("push_accepted", ok, 1);
      if (waits > 1) stalls++;
    end
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (write_finish_a) done = 1'b1;
      else tick();
    end
    check("finish_seen", done, 1);
    en_put_param = 1'b0;
    tick(); tick();

    if (!gaps) check("burst_no_stall", stalls, 0);
    check("a_writes", got_a.size(), n);
    for (int k = 0; k < n && k < got_a.size(); k++) begin
      check("a_addr", got_a[k].addr, k);
      check("a_data_ir", got_a[k].d_ir, {ents[k].i, ents[k].z, ents[k].k, ents[k].l});
      check("a_data_st", got_a[k].d_st, exp_state(ents[k].p, k));
      if (!gaps) check("a_consecutive", got_a[k].cyc - got_a[0].cyc, k);
    end
    check("a_entry_count", entry_count_a, n);
    check("a_overflow", overflow_a, 0);
    check("a_finish_pulses", fin_a, 1);

    cap_b = 4;
    exp_b = (n < cap_b) ? n : cap_b;
    check("b_writes", got_b.size(), exp_b);
    for (int k = 0; k < exp_b && k < got_b.size(); k++) begin
      check("b_addr", got_b[k].addr, k);
      check("b_data_ir", got_b[k].d_ir, {ents[k].i, ents[k].z, ents[k].k, ents[k].l});
    end
    check("b_entry_count", entry_count_b, exp_b);
    check("b_overflow", overflow_b, (n > cap_b));
    check("b_finish_pulses", fin_b, 1);
  endtask

  vec_t vecs[4];

  initial begin
    bit ok;
    int waits;

    vecs[0] = '{e: '{i: 8'h12, z: 8'h34, k: 8'h56, l: 8'h78, p: 4'h3}, exp_ir: 32'h12345678, exp_st: 17'h13000};
    vecs[1] = '{e: '{i: 8'hff, z: 8'h00, k: 8'hff, l: 8'h00, p: 4'hf}, exp_ir: 32'hff00ff00, exp_st: 17'h1f000};
    vecs[2] = '{e: '{i: 8'h00, z: 8'h00, k: 8'h00, l: 8'h01, p: 4'h0}, exp_ir: 32'h00000001, exp_st: 17'h10000};
    vecs[3] = '{e: '{i: 8'ha5, z: 8'h5a, k: 8'hc3, l: 8'h3c, p: 4'h9}, exp_ir: 32'ha55ac33c, exp_st: 17'h19000};

    rst_n = 1'b0; en_put_param = 1'b0; in_valid = 1'b0; last_in = 1'b0;
    i_in = '0; z_in = '0; k_in = '0; l_in = '0; position_in = '0;

    // Reset and idle: everything low.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("reset_outputs_zero", any_out(), 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_outputs_zero", any_out(), 0);
    end

    // Single-entry rounds with exact cycle timing.
    for (int v = 0; v < 4; v++) begin
      en_put_param = 1'b1;
      tick();
      check("tbl_ready_in_run", in_ready_a, 1);
      i_in = vecs[v].e.i; z_in = vecs[v].e.z; k_in = vecs[v].e.k; l_in = vecs[v].e.l;
      position_in = vecs[v].e.p; last_in = 1'b1; in_valid = 1'b1;
      tick();                                   // accept edge
      in_valid = 1'b0; last_in = 1'b0;
      check("tbl_no_write_yet", we_ir_a, 0);
      check("tbl_ready_in_flush", in_ready_a, 0);
      tick();                                   // write visible
      check("tbl_we_ir", we_ir_a, 1);
      check("tbl_we_st", we_st_a, 1);
      check("tbl_waddr", waddr_ir_a, 0);
      check("tbl_wdata_ir", wdata_ir_a, vecs[v].exp_ir);
      check("tbl_wdata_st", wdata_st_a, vecs[v].exp_st);
      tick();
      check("tbl_we_one_cycle", we_ir_a, 0);
      check("tbl_finish_early", write_finish_a, 0);
      check("tbl_data_hold", wdata_ir_a, vecs[v].exp_ir);
      tick();
      check("tbl_finish", write_finish_a, 1);
      check("tbl_entry_count", entry_count_a, 1);
      en_put_param = 1'b0;
      tick();
      check("tbl_finish_pulse", write_finish_a, 0);
      check("tbl_count_hold", entry_count_a, 1);
      tick();
    end

    // Back-to-back burst of 6: dut_a writes 0..5, dut_b overflows after 4.
    run_round(6, 1'b0);

    // Abort after 2 of 5 entries accepted.
    clear_mon();
    en_put_param = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      push(rand_ent(), 1'b0, ok, waits);
      check("abort_push_accepted", ok, 1);
    end
    en_put_param = 1'b0;
    i_in = 8'h99; in_valid = 1'b1;
    repeat (4) tick();
    check("abort_ready_low", in_ready_a, 0);
    in_valid = 1'b0;
    tick(); tick();
    check("abort_at_most_2", (got_a.size() <= 2), 1);
    check("abort_no_finish", fin_a, 0);
    check("abort_count_hold", entry_count_a, got_a.size());
    check("abort_we_low", we_ir_a, 0);
    for (int k = 0; k < got_a.size(); k++) check("abort_addr", got_a[k].addr, k);

    // Restart after abort: address 0 again, overflow cleared on dut_b.
    run_round(3, 1'b1);

    // Randomised rounds with input gaps.
    for (int r = 0; r < 6; r++) run_round($urandom_range(1, 10), 1'b1);

    // Reset while flushing: nothing may be written after release.
    en_put_param = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      push(rand_ent(), (k == 2), ok, waits);
      check("rst_push_accepted", ok, 1);
    end
    rst_n = 1'b0; en_put_param = 1'b0;
    tick();
    clear_mon();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post_reset_zero", any_out(), 0);
    end
    check("post_reset_writes", got_a.size() + got_b.size(), 0);
    check("post_reset_finish", fin_a + fin_b, 0);

    check("mirror_ports", mirror_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
